// File: rtl/nios2_mul_sequencer_if.sv
// Bundles the request/response handshake and the multiplier-cell port of nios2_mul_sequencer.
interface nios2_mul_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1;
    logic [31:0] mul_p2;
    logic [31:0] mul_p3;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  mul_p1, mul_p2, mul_p3,
        output req_ready, rsp_valid, rsp_data,
        output mul_src1, mul_src2, mul_en
    );

    // Requester / consumer / multiplier-cell side
    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        output mul_p1, mul_p2, mul_p3,
        input  req_ready, rsp_valid, rsp_data,
        input  mul_src1, mul_src2, mul_en
    );
endinterface

// File: rtl/nios2_mul_sequencer.sv
// Sequences a 32x32 Nios II multiply over a three-product 16x16 cell and returns lo/hi word.
module nios2_mul_sequencer (
    input  logic                  clk,
    input  logic                  reset_n,
    nios2_mul_sequencer_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned HW = 16;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, COLLECT, RESP} state_t;

    state_t          state, state_next;
    logic [1:0]      op, op_next;
    logic [DW-1:0]   a, a_next, b, b_next;
    logic [DW-1:0]   q0, q0_next, q1, q1_next, q2, q2_next;
    logic [DW-1:0]   rsp_data_next, mul_src1_next, mul_src2_next;
    logic            req_ready_next, rsp_valid_next, mul_en_next;

    logic [DW-1:0]   lo0, lo1, lo2;
    logic [DW:0]     mid;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   hi;

    // Partial-product combine: MUL uses the live cell outputs, MULX the captured LO pass plus live A_hi*B_hi
    always_comb begin
        lo0  = (op == OP_MUL) ? bus.mul_p1 : q0;
        lo1  = (op == OP_MUL) ? bus.mul_p2 : q1;
        lo2  = (op == OP_MUL) ? bus.mul_p3 : q2;
        mid  = (DW+1)'(lo1) + (DW+1)'(lo2);
        prod = {bus.mul_p1, DW'(0)} + ((2*DW)'(mid) << HW) + (2*DW)'(lo0);
        hi   = prod[2*DW-1:DW];
        if ((op == OP_MULXSU || op == OP_MULXSS) && a[DW-1]) begin
            hi = hi - b;
        end
        if (op == OP_MULXSS && b[DW-1]) begin
            hi = hi - a;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next    = state;
        op_next       = op;
        a_next        = a;
        b_next        = b;
        q0_next       = q0;
        q1_next       = q1;
        q2_next       = q2;
        rsp_data_next = bus.rsp_data;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    op_next    = bus.req_op;
                    a_next     = bus.req_src1;
                    b_next     = bus.req_src2;
                    state_next = ISSUE_LO;
                end
            end
            ISSUE_LO: begin
                state_next = (op == OP_MUL) ? COLLECT : ISSUE_HI;
            end
            ISSUE_HI: begin
                q0_next    = bus.mul_p1;
                q1_next    = bus.mul_p2;
                q2_next    = bus.mul_p3;
                state_next = COLLECT;
            end
            COLLECT: begin
                if (op == OP_MUL) begin
                    q0_next       = bus.mul_p1;
                    q1_next       = bus.mul_p2;
                    q2_next       = bus.mul_p3;
                    rsp_data_next = prod[DW-1:0];
                end else begin
                    rsp_data_next = hi;
                end
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        req_ready_next = (state_next == IDLE);
        rsp_valid_next = (state_next == RESP);
        mul_en_next    = (state_next == ISSUE_LO) || (state_next == ISSUE_HI);
        mul_src1_next  = '0;
        mul_src2_next  = '0;
        if (state_next == ISSUE_LO) begin
            mul_src1_next = a_next;
            mul_src2_next = b_next;
        end else if (state_next == ISSUE_HI) begin
            mul_src1_next = {HW'(0), a_next[DW-1:HW]};
            mul_src2_next = {HW'(0), b_next[DW-1:HW]};
        end
    end

    // State, operand, partial-product and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            op            <= OP_MUL;
            a             <= '0;
            b             <= '0;
            q0            <= '0;
            q1            <= '0;
            q2            <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.mul_en    <= 1'b0;
            bus.mul_src1  <= '0;
            bus.mul_src2  <= '0;
        end else begin
            state         <= state_next;
            op            <= op_next;
            a             <= a_next;
            b             <= b_next;
            q0            <= q0_next;
            q1            <= q1_next;
            q2            <= q2_next;
            bus.req_ready <= req_ready_next;
            bus.rsp_valid <= rsp_valid_next;
            bus.rsp_data  <= rsp_data_next;
            bus.mul_en    <= mul_en_next;
            bus.mul_src1  <= mul_src1_next;
            bus.mul_src2  <= mul_src2_next;
        end
    end
endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Directed bench for nios2_mul_sequencer with a behavioural 16x16 cell and a result scoreboard.
module tb_nios2_mul_sequencer;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    int   en_cnt;
    logic [31:0] exp_q[$];

    nios2_mul_sequencer_if bus ();

    nios2_mul_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three-product cell: registers on an enabled edge, visible the next cycle
    always @(posedge clk) begin
        if (bus.mul_en) begin
            bus.mul_p1 <= 32'(bus.mul_src1[15:0]) * 32'(bus.mul_src2[15:0]);
            bus.mul_p2 <= 32'(bus.mul_src1[15:0]) * 32'(bus.mul_src2[31:16]);
            bus.mul_p3 <= 32'(bus.mul_src1[31:16]) * 32'(bus.mul_src2[15:0]);
        end
    end

    // Counts clock edges on which the cell is enabled
    always @(posedge clk) begin
        if (bus.mul_en) en_cnt <= en_cnt + 1;
    end

    // Reference result from full 64-bit signed/unsigned arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = (op[1]) ? $signed({{32{a[31]}}, a}) : $signed({32'h0, a});
        sb = (op == 2'b11) ? $signed({{32{b[31]}}, b}) : $signed({32'h0, b});
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, waits for the response, checks latency, data and cell-enable count; leaves FSM in RESP
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int exp_en, input bit disturb);
        int lat;
        int en0;
        logic [31:0] exp;
        @(negedge clk);
        check("req_ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        exp_q.push_back(model(op, a, b));
        en0 = en_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (disturb && lat == 2) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 2'b00;
                bus.req_src1  = 32'h1234_5678;
                bus.req_src2  = 32'h9ABC_DEF0;
            end
            if (disturb && lat == 3) bus.req_valid = 1'b0;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        exp = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, exp);
        check("mul_en_cycles", 32'(en_cnt - en0), 32'(exp_en));
        exp_q.push_front(exp);
    endtask

    // Holds backpressure for `hold` cycles, then accepts and checks return to IDLE
    task automatic finish_rsp(input int hold);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_rsp_data", bus.rsp_data, exp);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_mul_en", 32'(bus.mul_en), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int rsp_seen;
        tests         = 0;
        fails         = 0;
        en_cnt        = 0;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_data", bus.rsp_data, 32'd0);
        check("reset_mul_en", 32'(bus.mul_en), 32'd0);
        check("reset_mul_src1", bus.mul_src1, 32'd0);
        check("reset_mul_src2", bus.mul_src2, 32'd0);

        // Main function across op types
        run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 3, 1, 1'b0);
        check("mul_const", bus.rsp_data, 32'h000B_000F);
        finish_rsp(0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 2, 1'b0);
        check("mulxuu_const", bus.rsp_data, 32'hFFFF_FFFE);
        finish_rsp(0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 2, 1'b0);
        check("mulxsu_const", bus.rsp_data, 32'hFFFF_FFFF);
        finish_rsp(0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 4, 2, 1'b0);
        finish_rsp(0);
        run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 4, 2, 1'b0);
        check("mulxss_min", bus.rsp_data, 32'h4000_0000);
        finish_rsp(0);
        run_op(2'b11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4, 2, 1'b0);
        finish_rsp(0);
        run_op(2'b10, 32'h8765_4321, 32'hFEDC_BA98, 4, 2, 1'b0);
        finish_rsp(0);
        run_op(2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3, 1, 1'b0);
        finish_rsp(0);

        // Backpressure: 5 held cycles, accepted on the 6th
        run_op(2'b11, 32'h1234_ABCD, 32'h8000_0001, 4, 2, 1'b0);
        finish_rsp(5);

        // Operand changes and a stray request during ISSUE_HI are ignored
        run_op(2'b11, 32'hC000_0003, 32'h4000_0007, 4, 2, 1'b1);
        finish_rsp(0);
        rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mul_en) rsp_seen++;
        end
        check("no_second_op", 32'(rsp_seen), 32'd0);

        // Reset during ISSUE_HI drops the op
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_src1  = 32'hFFFF_0000;
        bus.req_src2  = 32'h0000_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_mul_en", 32'(bus.mul_en), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mul_en", 32'(bus.mul_en), 32'd0);
        rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        check("rst_no_rsp", 32'(rsp_seen), 32'd0);
        run_op(2'b00, 32'd3, 32'd5, 3, 1, 1'b0);
        check("post_reset_mul", bus.rsp_data, 32'h0000_000F);
        finish_rsp(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
